pingpong_macro_scheduler: RTL and testbench
===========================================

// Module: pingpong_macro_scheduler
// PURPOSE
//  Sequences a Tile's PIM macros under ping-pong weight rewriting. Macros form two banks (ping=0, pong=1).
//  While task t computes on bank t%2, weights for task t+1 are rewritten into bank (t+1)%2.
//  Drives rewrite enables/addresses toward Weight_SRAM and the macros, and compute enables toward the Core/MVMU.
//  Compute is back-pressured by cmp_ready from the result path.
// PARAMETERS
//  NUM_MACRO  8   total macros; NUM_MACRO/2 per bank; must be even
//  CNT_W      32  width of cycle counters and of rw_addr/cmp_addr
//  TASK_W     16  width of task count and task indices
// PORTS
//  clk                input   1       clock; single clock domain
//  RSTn               input   1       asynchronous, active-low reset
//  start              input   1       1-cycle pulse; sampled only in IDLE
//  num_tasks          input   TASK_W  number of weight tiles to process; latched on start
//  rmc_of_each_macro  input   CNT_W   rewrite cycles per macro (rows); latched on start
//  compute_cycles     input   CNT_W   compute beats per task; latched on start
//  cmp_ready          input   1       downstream accepts a compute beat this cycle
//  busy               output  1       high from the cycle after start until the last compute beat
//  done               output  1       1-cycle pulse when the job completes
//  rw_en              output  1       rewrite active this cycle
//  rw_bank            output  1       bank being rewritten
//  rw_addr            output  CNT_W   row index within the macro, 0..rmc-1
//  rw_task            output  TASK_W  task whose weights are being written
//  cmp_en             output  1       compute beat offered this cycle
//  cmp_bank           output  1       bank being computed
//  cmp_addr           output  CNT_W   beat index, 0..compute_cycles-1
//  cmp_task           output  TASK_W  task being computed
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0. Takes effect immediately, mid-job included.
//    The job is abandoned and nothing resumes after reset release.
//  All outputs are registered. Config is latched when start is accepted.
//    A value of 0 in rmc or compute_cycles is treated as 1.
//  start while busy: ignored.
//  start with num_tasks==0: done=1 on the next cycle; busy, rw_en and cmp_en stay 0.
//  FSM states:
//    IDLE    -> PRELOAD on accepted start.
//    PRELOAD rewrites task0 into bank0; compute is idle.
//    OVERLAP computes task t on bank t%2 while rewriting task t+1 into bank (t+1)%2.
//    DRAIN   computes the last task only.
//  Counter rules:
//    Rewrite beat: every cycle rw_en=1, rw_addr increments. The last beat is rw_addr==rmc-1.
//    Compute beat: the cycle cmp_en && cmp_ready. cmp_addr increments only on a beat.
//      While cmp_ready=0, cmp_en and cmp_addr hold. The last beat is cmp_addr==C-1 with cmp_ready=1.
//    In OVERLAP, the side that finishes first drops its enable and waits. The phase ends on the edge
//      where the remaining side completes its last beat.
//  Transitions (taken on the final-beat edge; the next phase's enables are high the following cycle, no bubble):
//    PRELOAD done: N==1 -> DRAIN (task0); else -> OVERLAP with t=0.
//    OVERLAP done: t++. If t==N-1 -> DRAIN (task N-1, bank (N-1)%2); else -> OVERLAP.
//    DRAIN done -> IDLE. The next cycle has done=1 and busy=0.
//  Phase length is max(rmc, C+stall cycles).
//    Unstalled total busy cycles = rmc + (N-1)*max(rmc,C) + C.
//  A bank is never rewritten and computed in the same cycle: rw_bank != cmp_bank whenever rw_en && cmp_en.
//  Task indices wrap at 2^TASK_W. N is limited to 2^TASK_W-1.
// TESTING
//  rmc=4,C=6,N=3,cmp_ready=1, start at cycle 0:
//    busy cycles 1..22; done at 23.
//    rw_task 0,1,2 into banks 0,1,0; cmp_task 0,1,2 on banks 0,1,0.
//  rmc=8,C=3,N=2:
//    OVERLAP lasts 8 cycles; cmp_en high for 3 of them, then low for 5.
//    done at cycle 8+8+3+1=20.
//  cmp_ready toggled 1,0 each cycle with rmc=2,C=4,N=2:
//    cmp_addr advances only on ready cycles; the phase stretches to 8 cycles.
//    No rw/cmp bank overlap at any cycle.
//  N=0: done=1 on cycle 1 only. N=1, rmc=0, C=0: one rewrite beat then one compute beat; done at cycle 3.
//  start pulsed again mid-job: no effect on any output trace.
//    Drop RSTn mid-OVERLAP: all outputs 0 immediately, and IDLE after release.
//  rmc=4096,C=100,N=2: done at cycle 4096+4096+100+1. rw_addr wraps 4095->0 between tasks.

Source files
------------

// File: rtl/pingpong_macro_scheduler.sv
// Ping-pong macro scheduler: rewrites task t+1 into one bank while task t computes on the other.
// Phases run PRELOAD -> OVERLAP* -> DRAIN; each phase ends once both of its sides have finished.
module pingpong_macro_scheduler #(
  parameter int NUM_MACRO = 8,
  parameter int CNT_W     = 32,
  parameter int TASK_W    = 16
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              start,
  input  logic [TASK_W-1:0] num_tasks,
  input  logic [CNT_W-1:0]  rmc_of_each_macro,
  input  logic [CNT_W-1:0]  compute_cycles,
  input  logic              cmp_ready,
  output logic              busy,
  output logic              done,
  output logic              rw_en,
  output logic              rw_bank,
  output logic [CNT_W-1:0]  rw_addr,
  output logic [TASK_W-1:0] rw_task,
  output logic              cmp_en,
  output logic              cmp_bank,
  output logic [CNT_W-1:0]  cmp_addr,
  output logic [TASK_W-1:0] cmp_task
);

  if ((NUM_MACRO % 2) != 0 || NUM_MACRO < 2) begin : g_bad_macro_cnt
    $error("NUM_MACRO must be even and at least 2");
  end

  typedef enum logic [1:0] {IDLE, PRELOAD, OVERLAP, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [TASK_W-1:0] ntask_q, ntask_d;
  logic [CNT_W-1:0]  rmc_q, rmc_d;
  logic [CNT_W-1:0]  ccyc_q, ccyc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rw_en_q, rw_en_d;
  logic [CNT_W-1:0]  rw_addr_q, rw_addr_d;
  logic [TASK_W-1:0] rw_task_q, rw_task_d;
  logic              cmp_en_q, cmp_en_d;
  logic [CNT_W-1:0]  cmp_addr_q, cmp_addr_d;
  logic [TASK_W-1:0] cmp_task_q, cmp_task_d;

  logic              rw_last, cmp_beat, cmp_last, phase_end;
  logic [TASK_W-1:0] nxt_task;

  always_comb begin
    state_d    = state_q;
    ntask_d    = ntask_q;
    rmc_d      = rmc_q;
    ccyc_d     = ccyc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rw_en_d    = rw_en_q;
    rw_addr_d  = rw_addr_q;
    rw_task_d  = rw_task_q;
    cmp_en_d   = cmp_en_q;
    cmp_addr_d = cmp_addr_q;
    cmp_task_d = cmp_task_q;

    rw_last   = rw_en_q && (rw_addr_q == rmc_q - CNT_W'(1));
    cmp_beat  = cmp_en_q && cmp_ready;
    cmp_last  = cmp_beat && (cmp_addr_q == ccyc_q - CNT_W'(1));
    // A side that already dropped its enable counts as finished.
    phase_end = (!rw_en_q || rw_last) && (!cmp_en_q || cmp_last);
    nxt_task  = cmp_task_q + TASK_W'(1);

    if (state_q == IDLE) begin
      if (start) begin
        ntask_d = num_tasks;
        rmc_d   = (rmc_of_each_macro == '0) ? CNT_W'(1) : rmc_of_each_macro;
        ccyc_d  = (compute_cycles == '0) ? CNT_W'(1) : compute_cycles;
        if (num_tasks == '0) begin
          done_d = 1'b1;
        end else begin
          state_d   = PRELOAD;
          busy_d    = 1'b1;
          rw_en_d   = 1'b1;
          rw_addr_d = '0;
          rw_task_d = '0;
        end
      end
    end else begin
      if (rw_en_q) begin
        if (rw_last) rw_en_d = 1'b0;
        else         rw_addr_d = rw_addr_q + CNT_W'(1);
      end
      if (cmp_beat) begin
        if (cmp_last) cmp_en_d = 1'b0;
        else          cmp_addr_d = cmp_addr_q + CNT_W'(1);
      end
      if (phase_end) begin
        rw_addr_d  = '0;
        cmp_addr_d = '0;
        if (state_q == PRELOAD) begin
          cmp_en_d   = 1'b1;
          cmp_task_d = '0;
          if (ntask_q == TASK_W'(1)) begin
            state_d = DRAIN;
            rw_en_d = 1'b0;
          end else begin
            state_d   = OVERLAP;
            rw_en_d   = 1'b1;
            rw_task_d = TASK_W'(1);
          end
        end else if (state_q == OVERLAP) begin
          cmp_en_d   = 1'b1;
          cmp_task_d = nxt_task;
          if (nxt_task == ntask_q - TASK_W'(1)) begin
            state_d = DRAIN;
            rw_en_d = 1'b0;
          end else begin
            state_d   = OVERLAP;
            rw_en_d   = 1'b1;
            rw_task_d = nxt_task + TASK_W'(1);
          end
        end else begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          rw_en_d    = 1'b0;
          cmp_en_d   = 1'b0;
          rw_task_d  = '0;
          cmp_task_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      ntask_q    <= '0;
      rmc_q      <= CNT_W'(1);
      ccyc_q     <= CNT_W'(1);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rw_en_q    <= 1'b0;
      rw_addr_q  <= '0;
      rw_task_q  <= '0;
      cmp_en_q   <= 1'b0;
      cmp_addr_q <= '0;
      cmp_task_q <= '0;
    end else begin
      state_q    <= state_d;
      ntask_q    <= ntask_d;
      rmc_q      <= rmc_d;
      ccyc_q     <= ccyc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rw_en_q    <= rw_en_d;
      rw_addr_q  <= rw_addr_d;
      rw_task_q  <= rw_task_d;
      cmp_en_q   <= cmp_en_d;
      cmp_addr_q <= cmp_addr_d;
      cmp_task_q <= cmp_task_d;
    end
  end

  // Bank parity is the low bit of the task index.
  assign busy     = busy_q;
  assign done     = done_q;
  assign rw_en    = rw_en_q;
  assign rw_bank  = rw_task_q[0];
  assign rw_addr  = rw_addr_q;
  assign rw_task  = rw_task_q;
  assign cmp_en   = cmp_en_q;
  assign cmp_bank = cmp_task_q[0];
  assign cmp_addr = cmp_addr_q;
  assign cmp_task = cmp_task_q;

endmodule

// File: tb/tb_pingpong_macro_scheduler.sv
// Bench for pingpong_macro_scheduler: a phase-level model builds the expected per-cycle trace,
// one negedge process compares the DUT to it, and literal values pin the model.
module tb_pingpong_macro_scheduler;
  localparam int CNT_W  = 32;
  localparam int TASK_W = 16;

  typedef struct packed {
    logic              busy, done, rw_en, rw_bank;
    logic [CNT_W-1:0]  rw_addr;
    logic [TASK_W-1:0] rw_task;
    logic              cmp_en, cmp_bank;
    logic [CNT_W-1:0]  cmp_addr;
    logic [TASK_W-1:0] cmp_task;
  } exp_t;

  logic              clk = 1'b0, RSTn = 1'b0, start = 1'b0, cmp_ready = 1'b0;
  logic [TASK_W-1:0] num_tasks = '0;
  logic [CNT_W-1:0]  rmc_i = '0, cyc_i = '0;
  logic              busy, done, rw_en, rw_bank, cmp_en, cmp_bank;
  logic [CNT_W-1:0]  rw_addr, cmp_addr;
  logic [TASK_W-1:0] rw_task, cmp_task;

  pingpong_macro_scheduler #(.NUM_MACRO(8), .CNT_W(CNT_W), .TASK_W(TASK_W)) dut (
    .clk(clk), .RSTn(RSTn), .start(start), .num_tasks(num_tasks),
    .rmc_of_each_macro(rmc_i), .compute_cycles(cyc_i), .cmp_ready(cmp_ready),
    .busy(busy), .done(done), .rw_en(rw_en), .rw_bank(rw_bank), .rw_addr(rw_addr),
    .rw_task(rw_task), .cmp_en(cmp_en), .cmp_bank(cmp_bank), .cmp_addr(cmp_addr),
    .cmp_task(cmp_task)
  );

  always #5 clk = ~clk;

  int   tcyc = 0;
  int   s = 0;
  int   n_cmp = 0, n_bad = 0;
  int   dut_done_at = -1;
  bit   chk_en = 1'b0;
  exp_t exq[$];

  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (job cycle %0d)", nm, act, req, tcyc - s);
    end
  endtask

  function automatic bit rdy(input int mode, input int j);
    return (mode == 0) ? 1'b1 : (j % 2 == 0);
  endfunction

  // Phase p computes task p-1 (if any) and rewrites task p (if any); it lasts until both finish.
  task automatic build_model(input int rmc, input int c, input int n, input int mode);
    exp_t e;
    int r, cc, j, i, beats;
    bit has_rw, has_cmp;
    exq.delete();
    e = '0;
    exq.push_back(e);
    r  = (rmc == 0) ? 1 : rmc;
    cc = (c == 0) ? 1 : c;
    j  = 1;
    if (n > 0) begin
      for (int p = 0; p <= n; p++) begin
        has_rw  = (p < n);
        has_cmp = (p > 0);
        i = 0;
        beats = 0;
        do begin
          e = '0;
          e.busy = 1'b1;
          if (has_rw && i < r) begin
            e.rw_en = 1'b1; e.rw_addr = CNT_W'(i);
            e.rw_task = TASK_W'(p); e.rw_bank = p[0];
          end
          if (has_cmp && beats < cc) begin
            e.cmp_en = 1'b1; e.cmp_addr = CNT_W'(beats);
            e.cmp_task = TASK_W'(p - 1); e.cmp_bank = ~p[0];
            if (rdy(mode, j)) beats++;
          end
          exq.push_back(e);
          i++;
          j++;
        end while ((has_rw && i < r) || (has_cmp && beats < cc));
      end
    end
    e = '0;
    e.done = 1'b1;
    exq.push_back(e);
    e = '0;
    exq.push_back(e);
  endtask

  task automatic drive_job(input int rmc, input int c, input int n, input int mode,
                           input bit mid_start, input int done_lit);
    chk("model_done_idx", exq.size() - 2, done_lit);
    dut_done_at = -1;
    @(posedge clk); #1;
    start = 1'b1; num_tasks = TASK_W'(n); rmc_i = CNT_W'(rmc); cyc_i = CNT_W'(c);
    cmp_ready = rdy(mode, 0);
    s = tcyc;
    chk_en = 1'b1;
    for (int j = 1; j < exq.size(); j++) begin
      @(posedge clk); #1;
      start = mid_start && (j == 5 || j == 9);
      if (start) begin
        num_tasks = 7; rmc_i = 1; cyc_i = 1;
      end
      cmp_ready = rdy(mode, j);
    end
    @(negedge clk); #1;
    chk_en = 1'b0;
    start = 1'b0;
    chk("done_cycle", dut_done_at, done_lit);
  endtask

  always @(negedge clk) begin
    int   j;
    exp_t e;
    if (chk_en) begin
      j = tcyc - s;
      if (j >= 0 && j < exq.size()) begin
        e = exq[j];
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
        chk("rw_en", rw_en, e.rw_en);
        chk("cmp_en", cmp_en, e.cmp_en);
        if (e.rw_en) begin
          chk("rw_addr", rw_addr, e.rw_addr);
          chk("rw_task", rw_task, e.rw_task);
          chk("rw_bank", rw_bank, e.rw_bank);
        end
        if (e.cmp_en) begin
          chk("cmp_addr", cmp_addr, e.cmp_addr);
          chk("cmp_task", cmp_task, e.cmp_task);
          chk("cmp_bank", cmp_bank, e.cmp_bank);
        end
        if (rw_en && cmp_en) chk("bank_clash", longint'(rw_bank == cmp_bank), 0);
        if (done && dut_done_at < 0) dut_done_at = j;
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk(nm, longint'({busy, done, rw_en, rw_bank, cmp_en, cmp_bank}), 0);
    chk({nm, "_addr"}, longint'(rw_addr | cmp_addr), 0);
    chk({nm, "_task"}, longint'(rw_task | cmp_task), 0);
  endtask

  initial begin
    int ovl_cmp;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    RSTn = 1'b1;
    cmp_ready = 1'b1;

    build_model(4, 6, 3, 0);
    chk("pin_rw_task_c11", exq[11].rw_task, 2);
    chk("pin_rw_bank_c11", exq[11].rw_bank, 0);
    chk("pin_cmp_bank_c11", exq[11].cmp_bank, 1);
    chk("pin_busy_c22", exq[22].busy, 1);
    drive_job(4, 6, 3, 0, 1'b0, 23);

    build_model(8, 3, 2, 0);
    ovl_cmp = 0;
    for (int k = 9; k <= 16; k++) ovl_cmp += exq[k].cmp_en;
    chk("pin_overlap_cmp_cycles", ovl_cmp, 3);
    drive_job(8, 3, 2, 0, 1'b0, 20);

    build_model(2, 4, 2, 1);
    chk("pin_stall_overlap_end", exq[10].cmp_addr, 3);
    drive_job(2, 4, 2, 1, 1'b0, 19);

    build_model(5, 5, 0, 0);
    drive_job(5, 5, 0, 0, 1'b0, 1);

    build_model(0, 0, 1, 0);
    drive_job(0, 0, 1, 0, 1'b0, 3);

    build_model(4, 6, 3, 0);
    drive_job(4, 6, 3, 0, 1'b1, 23);

    build_model(4096, 100, 2, 0);
    chk("pin_wrap_last_row", exq[4096].rw_addr, 4095);
    chk("pin_wrap_first_row", exq[4097].rw_addr, 0);
    drive_job(4096, 100, 2, 0, 1'b0, 8293);

    // Asynchronous reset in the middle of OVERLAP.
    @(posedge clk); #1;
    start = 1'b1; num_tasks = 3; rmc_i = 4; cyc_i = 6; cmp_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_reset_cmp_en", cmp_en, 1);
    chk("pre_reset_rw_en", rw_en, 1);
    #2;
    RSTn = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    RSTn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("after_release");

    build_model(3, 2, 4, 0);
    drive_job(3, 2, 4, 0, 1'b0, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
